// File: rtl/accelerator_pkg.sv
// Shared types for the accelerator's OBI memory-side blocks.
package accelerator_pkg;

  localparam int unsigned OBI_MAX_LATENCY = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WAIT,
    GNT_READY
  } gnt_state_e;

  // Merge write data into an existing word, one byte lane per enable bit.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response delay line; the last stage drives the OBI response ports.
module obi_resp_pipe
  import accelerator_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic      clk,
  input  logic      n_reset,
  input  obi_resp_t resp_i,
  output obi_resp_t resp_o
);

  obi_resp_t stage_q [LATENCY];

  // Shift responses one stage per cycle; reset empties every stage.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= resp_i;
      for (int unsigned i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/obi_sram_responder.sv
// OBI slave data memory with configurable grant stall, credit limit and response latency.
module obi_sram_responder
  import accelerator_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned GNT_STALL       = 0,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [1:0]  STALL_MAX = 2'(GNT_STALL);
  localparam logic [2:0]  OUT_MAX   = 3'(MAX_OUTSTANDING);

  logic [31:0]      mem [MEM_WORDS];

  gnt_state_e       state_q, state_d;
  logic [1:0]       stall_cnt_q, stall_cnt_d;
  logic [2:0]       outstanding_q, outstanding_d;

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic             stall_done;
  logic             credit;
  logic             gnt;
  obi_resp_t        resp_new;
  obi_resp_t        resp_out;

  assign offset   = data_addr_i - ADDR_BASE;
  assign in_range = offset < MEM_BYTES;
  assign word_idx = offset[IDX_W+1:2];

  // IDLE implies stall_cnt == 0, READY implies stall_cnt == GNT_STALL,
  // so the state alone tells whether the stall requirement is met.
  assign stall_done = (state_q == GNT_READY) ||
                      ((state_q == GNT_IDLE) && (STALL_MAX == 2'd0));

  // A response leaving this cycle frees its slot at the same edge, which
  // lets RESP_LATENCY = 1 sustain one grant per cycle.
  assign credit = (outstanding_q < OUT_MAX) || resp_out.valid;

  assign gnt        = data_req_i && stall_done && credit && n_reset;
  assign data_gnt_o = gnt;

  // Grant FSM and stall counter state registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= GNT_IDLE;
      stall_cnt_q   <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Next grant state: count stall cycles while req is held, restart on grant or drop.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (!data_req_i) begin
      state_d     = GNT_IDLE;
      stall_cnt_d = '0;
    end else if (gnt) begin
      stall_cnt_d = '0;
      state_d     = (STALL_MAX == 2'd0) ? GNT_READY : GNT_WAIT;
    end else begin
      if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + 2'd1;
      state_d = (stall_cnt_d == STALL_MAX) ? GNT_READY : GNT_WAIT;
    end
  end

  // Outstanding count: +1 per grant, -1 per response, unchanged when both coincide.
  always_comb begin
    outstanding_d = outstanding_q;
    if (gnt && !resp_out.valid) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!gnt && resp_out.valid) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  // Form the response at the grant edge; reads see the array before this edge's write.
  always_comb begin
    resp_new = '0;
    if (gnt) begin
      resp_new.valid = 1'b1;
      resp_new.err   = !in_range;
      if (!data_we_i && in_range) resp_new.rdata = mem[word_idx];
    end
  end

  // Byte-enabled write into the array; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      mem[word_idx] <= be_merge(mem[word_idx], data_wdata_i, data_be_i);
    end
  end

  obi_resp_pipe #(
    .LATENCY(RESP_LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .n_reset(n_reset),
    .resp_i (resp_new),
    .resp_o (resp_out)
  );

  assign data_rvalid_o = resp_out.valid;
  assign data_rdata_o  = resp_out.rdata;
  assign data_err_o    = resp_out.err;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench for obi_sram_responder across three parameter sets.
module tb_obi_sram_responder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req0, req1, req2;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt0, gnt1, gnt2;
  logic        rvalid0, rvalid1, rvalid2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        err0, err1, err2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Credit-limit expectations, bit/entry c = cycle c.
  logic [10:0] exp_g  = 11'b000_0011_0011;
  logic [10:0] exp_rv = 11'b011_0011_0000;
  int unsigned exp_o [11] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 1, 0};

  always #5 clk = ~clk;

  // Default parameters: RESP_LATENCY 1, GNT_STALL 0, MAX_OUTSTANDING 2.
  obi_sram_responder #(
    .MEM_WORDS(1024), .ADDR_BASE(32'h0), .RESP_LATENCY(1), .GNT_STALL(0), .MAX_OUTSTANDING(2)
  ) u0 (
    .clk(clk), .n_reset(n_reset), .data_req_i(req0), .data_gnt_o(gnt0),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid0), .data_rdata_o(rdata0), .data_err_o(err0)
  );

  obi_sram_responder #(
    .MEM_WORDS(1024), .ADDR_BASE(32'h0), .RESP_LATENCY(3), .GNT_STALL(2), .MAX_OUTSTANDING(2)
  ) u1 (
    .clk(clk), .n_reset(n_reset), .data_req_i(req1), .data_gnt_o(gnt1),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid1), .data_rdata_o(rdata1), .data_err_o(err1)
  );

  obi_sram_responder #(
    .MEM_WORDS(1024), .ADDR_BASE(32'h0), .RESP_LATENCY(4), .GNT_STALL(0), .MAX_OUTSTANDING(2)
  ) u2 (
    .clk(clk), .n_reset(n_reset), .data_req_i(req2), .data_gnt_o(gnt2),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid2), .data_rdata_o(rdata2), .data_err_o(err2)
  );

  task automatic chk1(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    addr = '0; we = 1'b0; be = '0; wdata = '0;

    // Reset state, with a request pending on u0.
    repeat (2) @(posedge clk);
    #1;
    req0 = 1'b1;
    #1;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk32("rst_rdata0", rdata0, 32'h0);
    chk1("rst_err0", err0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    chk1("rst_rvalid2", rvalid2, 1'b0);
    chk32("rst_out2", 32'(u2.outstanding_q), 32'd0);
    req0 = 1'b0;
    n_reset = 1'b1;

    // Write then read, latency 1.
    next_cycle(); req0 = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'hDEADBEEF; #1;
    chk1("wr_gnt", gnt0, 1'b1);
    chk1("wr_pre_rvalid", rvalid0, 1'b0);
    next_cycle(); we = 1'b0; #1;
    chk1("wr_rvalid", rvalid0, 1'b1);
    chk32("wr_rdata", rdata0, 32'h0);
    chk1("wr_err", err0, 1'b0);
    chk1("rd_gnt", gnt0, 1'b1);
    next_cycle(); req0 = 1'b0; #1;
    chk1("rd_rvalid", rvalid0, 1'b1);
    chk32("rd_rdata", rdata0, 32'hDEADBEEF);
    chk1("rd_err", err0, 1'b0);
    next_cycle(); #1;
    chk1("idle_rvalid", rvalid0, 1'b0);
    chk32("idle_rdata", rdata0, 32'h0);

    // Byte enables, back-to-back grants.
    next_cycle(); req0 = 1'b1; we = 1'b1; addr = 32'h80; be = 4'hF; wdata = 32'h11223344; #1;
    chk1("be_pre_gnt", gnt0, 1'b1);
    next_cycle(); be = 4'b0101; wdata = 32'hAABBCCDD; #1;
    chk1("be_wr_gnt", gnt0, 1'b1);
    chk1("be_pre_rvalid", rvalid0, 1'b1);
    next_cycle(); we = 1'b0; #1;
    chk1("be_rd_gnt", gnt0, 1'b1);
    chk1("be_wr_rvalid", rvalid0, 1'b1);
    next_cycle(); req0 = 1'b0; #1;
    chk1("be_rd_rvalid", rvalid0, 1'b1);
    chk32("be_rd_rdata", rdata0, 32'h11BB33DD);

    // Out of range at 0x1000 (aliases word 0 if truncated), plus last word 0xFFC.
    next_cycle(); req0 = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'h12345678; #1;
    chk1("oor_pre_gnt", gnt0, 1'b1);
    next_cycle(); addr = 32'h1000; wdata = 32'hFFFFFFFF; #1;
    chk1("oor_wr_gnt", gnt0, 1'b1);
    chk1("oor_pre_err", err0, 1'b0);
    next_cycle(); we = 1'b0; #1;
    chk1("oor_wr_rvalid", rvalid0, 1'b1);
    chk1("oor_wr_err", err0, 1'b1);
    chk32("oor_wr_rdata", rdata0, 32'h0);
    next_cycle(); addr = 32'h0; #1;
    chk1("oor_rd_err", err0, 1'b1);
    chk32("oor_rd_rdata", rdata0, 32'h0);
    next_cycle(); we = 1'b1; addr = 32'hFFC; wdata = 32'hCAFEF00D; #1;
    chk32("oor_word0_kept", rdata0, 32'h12345678);
    chk1("oor_word0_err", err0, 1'b0);
    next_cycle(); we = 1'b0; #1;
    chk1("last_wr_err", err0, 1'b0);
    next_cycle(); req0 = 1'b0; #1;
    chk32("last_rd_rdata", rdata0, 32'hCAFEF00D);
    chk1("last_rd_err", err0, 1'b0);

    // Grant stall 2, latency 3: a dropped request restarts the stall count.
    we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'h1;
    next_cycle(); req1 = 1'b1; #1;
    chk1("stl_a0_gnt", gnt1, 1'b0);
    next_cycle(); #1;
    chk1("stl_a1_gnt", gnt1, 1'b0);
    next_cycle(); req1 = 1'b0; #1;
    chk1("stl_drop_gnt", gnt1, 1'b0);
    next_cycle(); req1 = 1'b1; #1;
    chk1("stl_c0_gnt", gnt1, 1'b0);
    next_cycle(); #1;
    chk1("stl_c1_gnt", gnt1, 1'b0);
    next_cycle(); #1;
    chk1("stl_c2_gnt", gnt1, 1'b1);
    next_cycle(); req1 = 1'b0; #1;
    chk1("stl_c3_gnt", gnt1, 1'b0);
    chk1("stl_c3_rvalid", rvalid1, 1'b0);
    next_cycle(); #1;
    chk1("stl_c4_rvalid", rvalid1, 1'b0);
    next_cycle(); #1;
    chk1("stl_c5_rvalid", rvalid1, 1'b1);
    chk1("stl_c5_err", err1, 1'b0);
    chk32("stl_c5_rdata", rdata1, 32'h0);
    next_cycle(); #1;
    chk1("stl_c6_rvalid", rvalid1, 1'b0);

    // Credit limit 2, latency 4, request held for cycles 0..7.
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      req2 = (c < 8);
      we = 1'b1; addr = 32'h100; be = 4'hF; wdata = 32'(c);
      #1;
      chk1($sformatf("crd_c%0d_gnt", c), gnt2, exp_g[c]);
      chk1($sformatf("crd_c%0d_rvalid", c), rvalid2, exp_rv[c]);
      chk32($sformatf("crd_c%0d_out", c), 32'(u2.outstanding_q), exp_o[c]);
      chk32($sformatf("crd_c%0d_rdata", c), rdata2, 32'h0);
    end
    req2 = 1'b0;

    // Reset one cycle after a grant on u1 (latency 3).
    we = 1'b1; addr = 32'h40;
    next_cycle(); req1 = 1'b1; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    chk1("mf_gnt", gnt1, 1'b1);
    next_cycle(); req1 = 1'b0; req0 = 1'b1; we = 1'b0; n_reset = 1'b0; #1;
    chk1("mf_rst_gnt0", gnt0, 1'b0);
    chk32("mf_rst_out1", 32'(u1.outstanding_q), 32'd0);
    chk1("mf_rst_rvalid1", rvalid1, 1'b0);
    next_cycle();
    chk1("mf_rst_gnt0_b", gnt0, 1'b0);
    req0 = 1'b0;
    n_reset = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      next_cycle(); #1;
      chk1($sformatf("mf_post%0d_rvalid1", c), rvalid1, 1'b0);
    end
    chk32("mf_post_out1", 32'(u1.outstanding_q), 32'd0);

    // Array contents survive reset.
    next_cycle(); req0 = 1'b1; we = 1'b0; addr = 32'h40; #1;
    chk1("keep_gnt", gnt0, 1'b1);
    next_cycle(); req0 = 1'b0; #1;
    chk1("keep_rvalid", rvalid0, 1'b1);
    chk32("keep_rdata", rdata0, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obi_sram_responder.md
# obi_sram_responder

OBI slave data memory that answers the vector LSU's (and the core's) OBI master port in the accelerator testbench and FPGA build. It accepts one request per grant, performs byte-enabled writes and word reads on an internal SRAM array, and returns exactly one response (rvalid) per granted request after a fixed latency. Grant stalls and outstanding-request limits are configurable, so master-side handshake corner cases can be exercised.

## Interface
- MEM_WORDS, 1024: depth of the 32-bit word array.
- ADDR_BASE, 32'h0000_0000: byte address mapped to word 0.
- RESP_LATENCY, 1: cycles from the grant edge to rvalid; legal range 1..4.
- GNT_STALL, 0: cycles `data_req_i` must be held before grant; legal range 0..3.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered requests; legal range 1..4.

- clk  in  1  clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  OBI request valid.
- data_gnt_o  out  1  OBI grant, combinational.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables, used for writes.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  32  read data, valid with rvalid.
- data_err_o  out  1  out-of-range access flag, valid with rvalid.

## Operation
- Word index = (data_addr_i − ADDR_BASE) >> 2. An access is out of range if (data_addr_i − ADDR_BASE) ≥ MEM_WORDS·4, computed as 32-bit unsigned.
- Grant conditions:
  - `data_gnt_o` = `data_req_i` & (stall_cnt == GNT_STALL) & (outstanding < MAX_OUTSTANDING) & `n_reset`.
  - stall_cnt saturates at GNT_STALL.
  - stall_cnt increments each cycle `data_req_i` is high and no grant is given.
  - stall_cnt clears to 0 on grant or when `data_req_i` is low.
- Handshake (clk edge where req & gnt):
  - Write: each byte lane i with `data_be_i`[i] = 1 is written. The response carries rdata = 0.
  - Read: the full word is captured regardless of be. The response carries the array value before any write granted at the same edge; a single request per edge makes this moot.
  - Out of range: a write is dropped, a read returns 0. err = 1 in the response.
- Responses:
  - Every granted request, read or write, produces exactly one rvalid pulse. The LSU waits on rvalid for stores.
  - Responses stay in grant order.
- outstanding counter, 3 bits:
  - +1 on grant, −1 on rvalid.
  - Unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Grant state machine:
  - IDLE: req low.
  - WAIT: req high, stall_cnt < GNT_STALL.
  - READY: stall_cnt == GNT_STALL; grant when credit is available.
  - Transitions are IDLE→WAIT/READY on req, READY→IDLE on grant with req dropped, any state→IDLE on req low.
  - With GNT_STALL = 0, WAIT is skipped.
- Memory contents are not cleared by reset. The array is initialised only by `$readmemh` in simulation.

## Timing
- Reset values: `data_gnt_o` 0, `data_rvalid_o` 0, `data_rdata_o` 0, `data_err_o` 0, stall_cnt 0, outstanding 0, response pipeline empty.
- `data_rvalid_o`, `data_rdata_o` and `data_err_o` are registered.
- A grant at edge N gives rvalid high during cycle N+RESP_LATENCY−1 → N+RESP_LATENCY, i.e. exactly RESP_LATENCY cycles later, for one cycle.
- rdata and err are 0 whenever rvalid is 0.
- Back-to-back grants are allowed each cycle while outstanding < MAX_OUTSTANDING. RESP_LATENCY = 1 with MAX_OUTSTANDING ≥ 1 gives full throughput, because the rvalid decrement coincides with the next grant.
- Reset asserted mid-operation: all in-flight responses are dropped, no rvalid after reset release, and the counters return to 0.
- A request dropped before grant is legal for this responder (non-OBI master). No state is retained except stall_cnt clearing.

## Structure
- `accelerator_pkg` gains:
  - typedef `obi_resp_t` {logic valid; logic err; logic [31:0] rdata;}.
  - localparam OBI_MAX_LATENCY = 4.
- Sub-module `obi_resp_pipe`: a RESP_LATENCY-deep shift register of `obi_resp_t` with async reset. Input is the response formed at the grant edge; output drives the rvalid, rdata and err ports.
- Top level contains the SRAM array, the grant FSM with stall_cnt, the outstanding counter, and the address decode.

## Test plan
- Write then read, RESP_LATENCY = 1: write 0xDEADBEEF to 0x40 with be = 1111, then read 0x40 → rvalid one cycle after each grant, read rdata = 0xDEADBEEF, err = 0.
- Byte enables: preload 0x11223344 at 0x80, write 0xAABBCCDD with be = 0101, read back → 0x11BB33DD.
- Stall and latency, GNT_STALL = 2, RESP_LATENCY = 3: req held from cycle 0 → gnt in cycle 2, rvalid in cycle 5, exactly one pulse.
- Credit limit, MAX_OUTSTANDING = 2, RESP_LATENCY = 4: req held high continuously → grants at cycles 0 and 1, none at 2–3; further grants at cycles 4 and 5 coincide with rvalid; outstanding never exceeds 2.
- Out-of-range: MEM_WORDS = 1024, write then read at 0x1000 → both responses have err = 1, read rdata = 0, array unchanged.
- Reset mid-flight, RESP_LATENCY = 3: grant at cycle 0, assert n_reset low at cycle 1 for one cycle → no rvalid ever follows, gnt low during reset, outstanding = 0 afterwards.
